// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; the history bit is kept by the caller.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_owner
);

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_owner = OWNER_I;
        if (req_i && req_d) begin
            gnt_owner = ~last;
        end else if (req_d) begin
            gnt_owner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the I-fetch and data ports,
// holding each access on the pins for LATENCY cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [BITS-1:0] i_addr,
    output logic [BITS-1:0] i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_wen,
    input  logic [BITS-1:0] d_addr,
    input  logic [BITS-1:0] d_wdata,
    output logic [BITS-1:0] d_rdata,
    output logic            d_ack,
    output logic            mem_wen,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    output logic            busy
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            wen_q, wen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0] wdata_q, wdata_d;
    logic [BITS-1:0] i_rdata_q, i_rdata_d;
    logic [BITS-1:0] d_rdata_q, d_rdata_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;

    logic gnt_valid;
    logic gnt_owner;

    mem_arb_rr2 u_rr2 (
        .req_i     (i_req),
        .req_d     (d_req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wen_d     = wen_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                    if (gnt_owner == OWNER_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wen_d   = d_wen;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = '0;
                        wen_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    // For writes this samples the word before it is overwritten.
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_I;
            last_q    <= OWNER_I;
            wen_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wen_q     <= wen_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    // Single write strobe in the last held cycle of a write access.
    assign mem_wen   = (state_q == ACCESS) && wen_q && (cnt_q == '0);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 instance on a word memory
// model plus a LATENCY=1 instance on an address-pattern memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic        mem_wen, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        l1_i_req;
    logic [31:0] l1_i_addr, l1_i_rdata, l1_d_rdata;
    logic        l1_i_ack, l1_d_ack, l1_mem_wen, l1_busy;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_d_req, l1_d_wen;
    logic [31:0] l1_d_addr, l1_d_wdata;

    logic [31:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_a;
    logic [31:0] pre_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BITS(32), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.BITS(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata),
        .i_ack(l1_i_ack),
        .d_req(l1_d_req), .d_wen(l1_d_wen), .d_addr(l1_d_addr),
        .d_wdata(l1_d_wdata), .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
        .mem_wen(l1_mem_wen), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[5:2]] <= mem_wdata;
        else if (pre_we) mem[pre_a] <= pre_d;
    end
    assign mem_rdata    = mem[mem_addr[5:2]];
    assign l1_mem_rdata = l1_mem_addr ^ 32'hA5A5_0000;

    task automatic preload(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_req = 0; i_addr = '0; d_req = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
        l1_i_req = 0; l1_i_addr = '0; l1_d_req = 0; l1_d_wen = 0;
        l1_d_addr = '0; l1_d_wdata = '0;
        pre_we = 0; pre_a = '0; pre_d = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({i_ack, d_ack, mem_wen, busy} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000", {i_ack, d_ack, mem_wen, busy});
        end
        vectors++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h ir %h dr %h want all 0",
                     mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_i_read;
        preload(4'd0, 32'h1234_5678);
        @(negedge clk);
        i_req = 1; i_addr = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL i_read_wen c%0d: got %b want 0", c, mem_wen);
            end
            vectors++;
            if (i_ack !== (c == 3)) begin
                miscompares++;
                $display("FAIL i_read_ack c%0d: got %b want %b", c, i_ack, c == 3);
            end
            vectors++;
            if (busy !== (c <= 3)) begin
                miscompares++;
                $display("FAIL i_read_busy c%0d: got %b want %b", c, busy, c <= 3);
            end
            if (c <= 2) begin
                vectors++;
                if (mem_addr !== 32'h0) begin
                    miscompares++;
                    $display("FAIL i_read_addr c%0d: got %h want 0", c, mem_addr);
                end
            end
            if (c == 3) begin
                vectors++;
                if (i_rdata !== 32'h1234_5678) begin
                    miscompares++;
                    $display("FAIL i_read_data: got %h want 12345678", i_rdata);
                end
                i_req = 0;
            end
        end
    endtask

    task automatic test_d_write_read;
        preload(4'd1, 32'h1111_2222);
        @(negedge clk);
        d_req = 1; d_wen = 1; d_addr = 32'h4; d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_wen !== (c == 2)) begin
                miscompares++;
                $display("FAIL d_wr_wen c%0d: got %b want %b", c, mem_wen, c == 2);
            end
            vectors++;
            if (d_ack !== (c == 3)) begin
                miscompares++;
                $display("FAIL d_wr_ack c%0d: got %b want %b", c, d_ack, c == 3);
            end
            if (c == 2) begin
                vectors++;
                if ({mem_addr, mem_wdata} !== {32'h4, 32'hDEAD_BEEF}) begin
                    miscompares++;
                    $display("FAIL d_wr_pins: got %h/%h want 4/deadbeef",
                             mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                vectors++;
                if (d_rdata !== 32'h1111_2222) begin
                    miscompares++;
                    $display("FAIL d_wr_old: got %h want 11112222", d_rdata);
                end
                d_req = 0; d_wen = 0;
            end
        end
        d_req = 1; d_wen = 0; d_addr = 32'h4; d_wdata = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL d_rd_wen c%0d: got %b want 0", c, mem_wen);
            end
            vectors++;
            if (d_ack !== (c == 3)) begin
                miscompares++;
                $display("FAIL d_rd_ack c%0d: got %b want %b", c, d_ack, c == 3);
            end
        end
        vectors++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL d_rd_data: got %h want deadbeef", d_rdata);
        end
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        preload(4'd4, 32'hAAAA_0004);
        preload(4'd5, 32'hBBBB_0005);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        i_req = 1; i_addr = 32'h10;
        d_req = 1; d_wen = 0; d_addr = 32'h14;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            vectors++;
            if (d_ack !== (c == 3 || c == 11)) begin
                miscompares++;
                $display("FAIL both_d_ack c%0d: got %b want %b", c, d_ack,
                         c == 3 || c == 11);
            end
            vectors++;
            if (i_ack !== (c == 7 || c == 15)) begin
                miscompares++;
                $display("FAIL both_i_ack c%0d: got %b want %b", c, i_ack,
                         c == 7 || c == 15);
            end
            if (c == 3) begin
                vectors++;
                if (d_rdata !== 32'hBBBB_0005) begin
                    miscompares++;
                    $display("FAIL both_d_data: got %h want bbbb0005", d_rdata);
                end
            end
            if (c == 7) begin
                vectors++;
                if (i_rdata !== 32'hAAAA_0004) begin
                    miscompares++;
                    $display("FAIL both_i_data: got %h want aaaa0004", i_rdata);
                end
            end
        end
        i_req = 0; d_req = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL both_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_req_drop;
        preload(4'd2, 32'h0);
        @(negedge clk);
        d_req = 1; d_wen = 1; d_addr = 32'h8; d_wdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                d_req = 0; d_wen = 0; d_addr = 32'h3C; d_wdata = 32'hFFFF_FFFF;
            end
            vectors++;
            if (mem_wen !== (c == 2)) begin
                miscompares++;
                $display("FAIL drop_wen c%0d: got %b want %b", c, mem_wen, c == 2);
            end
            vectors++;
            if (d_ack !== (c == 3)) begin
                miscompares++;
                $display("FAIL drop_ack c%0d: got %b want %b", c, d_ack, c == 3);
            end
            if (c == 2) begin
                vectors++;
                if ({mem_addr, mem_wdata} !== {32'h8, 32'hCAFE_F00D}) begin
                    miscompares++;
                    $display("FAIL drop_pins: got %h/%h want 8/cafef00d",
                             mem_addr, mem_wdata);
                end
            end
        end
        vectors++;
        if (mem[2] !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL drop_commit: got %h want cafef00d", mem[2]);
        end
    endtask

    task automatic test_reset_mid;
        preload(4'd3, 32'h55AA_55AA);
        @(negedge clk);
        d_req = 1; d_wen = 1; d_addr = 32'hC; d_wdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        vectors++;
        if (mem_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre_wen: got %b want 1", mem_wen);
        end
        rst_n = 0; d_req = 0; d_wen = 0;
        #1;
        vectors++;
        if ({mem_wen, busy, d_ack, i_ack} !== 4'b0) begin
            miscompares++;
            $display("FAIL rmid_async_ctl: got %b want 0000",
                     {mem_wen, busy, d_ack, i_ack});
        end
        vectors++;
        if ({mem_addr, mem_wdata} !== 64'b0) begin
            miscompares++;
            $display("FAIL rmid_async_pins: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({d_ack, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rmid_after c%0d: got ack/busy %b want 00", c,
                         {d_ack, busy});
            end
        end
        vectors++;
        if (mem[3] !== 32'h55AA_55AA) begin
            miscompares++;
            $display("FAIL rmid_mem: got %h want 55aa55aa", mem[3]);
        end
    endtask

    task automatic test_latency1;
        @(negedge clk);
        l1_i_req = 1; l1_i_addr = 32'h20;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (l1_i_ack !== (c == 2 || c == 5)) begin
                miscompares++;
                $display("FAIL l1_ack c%0d: got %b want %b", c, l1_i_ack,
                         c == 2 || c == 5);
            end
            vectors++;
            if (l1_mem_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL l1_wen c%0d: got %b want 0", c, l1_mem_wen);
            end
            if (c == 2) begin
                vectors++;
                if (l1_i_rdata !== 32'hA5A5_0020) begin
                    miscompares++;
                    $display("FAIL l1_data0: got %h want a5a50020", l1_i_rdata);
                end
                l1_i_addr = 32'h24;
            end
            if (c == 5) begin
                vectors++;
                if (l1_i_rdata !== 32'hA5A5_0024) begin
                    miscompares++;
                    $display("FAIL l1_data1: got %h want a5a50024", l1_i_rdata);
                end
                l1_i_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_i_read();
        test_d_write_read();
        test_simultaneous();
        test_req_drop();
        test_reset_mid();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer in front of the single-port behavioural word memory. It shares one memory instance between the CPU instruction-fetch port (read-only) and the data port (read/write). Each granted access holds the memory address stable for a programmable number of cycles, then returns the read data with a one-cycle acknowledge. It sits between the core's I/D request interfaces and the memory's `wen`/`a`/`d`/`q` pins.

## Interface
- `BITS`, 32, data and address width.
- `LATENCY`, 2, number of cycles the address is held on the memory per access. Must be ≥1.
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, asynchronous active-low reset.
- `i_req` in 1, instruction read request; held high until `i_ack`.
- `i_addr` in BITS, instruction byte address.
- `i_rdata` out BITS, instruction read data; valid when `i_ack` is high, held until the next I completion.
- `i_ack` out 1, one-cycle completion pulse for the I port.
- `d_req` in 1, data request; held high until `d_ack`.
- `d_wen` in 1, 1 = write, 0 = read.
- `d_addr` in BITS, data byte address.
- `d_wdata` in BITS, write data.
- `d_rdata` out BITS, data read data; valid with `d_ack`, held until the next D completion.
- `d_ack` out 1, one-cycle completion pulse for the D port.
- `mem_wen` out 1, to memory `wen`.
- `mem_addr` out BITS, to memory `a`.
- `mem_wdata` out BITS, to memory `d`.
- `mem_rdata` in BITS, from memory `q`. The memory read path is combinational.
- `busy` out 1, high in ACCESS and RESP.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any request is high, choose an owner.
  - Latch the owner, the address, the write data and wen. Write data and wen are forced to 0 when the owner is I.
  - Load `cnt = LATENCY-1` and go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration:**
  - A single request wins.
  - If both are requesting, grant the port that was not granted last (round-robin).
  - The `last` register resets to I, so D wins the first tie after reset.
- **ACCESS:**
  - `mem_addr`/`mem_wdata` are driven from the latched registers.
  - `mem_wen` = latched wen AND `cnt==0`, so there is exactly one write pulse per write access.
  - When `cnt==0`: capture `mem_rdata` into the owner's rdata register and go to RESP. For a write this captures the pre-write word.
  - Otherwise decrement `cnt`.
- **RESP:** pulse the owner's ack for one cycle, update `last`, return to IDLE.
- **Request dropped mid-access:** the access is not aborted. It completes and the ack still pulses. A write still commits.
- **Address handling:** addresses pass through unmodified. Alignment and offset decoding belong to the memory.
- **Inputs outside IDLE:** requester inputs are ignored outside IDLE. Only the latched copies reach the memory.
- **Reset values:** all registers, all outputs and `last` reset to 0/I; state resets to IDLE. Memory reset is generated at the top level by inverting `rst_n`, not inside this block.

## Timing
- Request first sampled high in IDLE at edge 0.
- ACCESS occupies cycles 1..LATENCY; `mem_wen` is high in cycle LATENCY only.
- Ack and rdata are visible in cycle LATENCY+1.
- Back-to-back throughput is one access per LATENCY+2 cycles.
- The IDLE cycle after RESP re-arbitrates. A requester may keep its request high across an ack to issue its next access.
- `rst_n` low at any point:
  - All outputs go to 0 immediately (asynchronously).
  - The in-flight access is dropped and no ack is issued.
  - `mem_wen` falls at once, so a partial write cannot commit.
- `cnt` width is `$clog2(LATENCY+1)`.

## Structure
- **Package `mem_arb_pkg`:** state enum {IDLE, ACCESS, RESP} and owner constants OWNER_I=0, OWNER_D=1.
- **Sub-module `mem_arb_rr2`:** a 2-way round-robin picker. Inputs: two requests and `last`. Outputs: a grant valid and the grant owner. It is purely combinational; the `last` register lives in the parent.
- The FSM, counter and datapath registers are in `mem_arbiter`.

## Test plan
- **Reset mid-access:** `rst_n` low during ACCESS of a D write → all outputs 0 at once, no `d_ack`, memory word unchanged, state IDLE after release.
- **Single I read (LATENCY=2):** memory offset 0x0 preloaded with 0x12345678; `i_req` with `i_addr`=0x0 at cycle 0 → `mem_addr`=0x0 in cycles 1–2, `i_ack` and `i_rdata`=0x12345678 in cycle 3, `mem_wen` never high.
- **D write then read:**
  - `d_wen`=1, `d_addr`=0x4, `d_wdata`=0xDEADBEEF → `mem_wen` high in cycle 2 only, `d_ack` in cycle 3.
  - Following read of 0x4 → `d_rdata`=0xDEADBEEF.
- **Simultaneous requests from reset:** `i_req` and `d_req` both held high → D acked in cycle 3, I acked in cycle 7, then grants alternate D/I every 4 cycles.
- **Request drop:** `d_req` dropped in cycle 1 of a write to 0x8 → `mem_wen` still pulses in cycle 2, `d_ack` in cycle 3, memory holds the new data.
- **LATENCY=1 build:** single I read → ack in cycle 2; two back-to-back reads → second ack in cycle 5.
